// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerator datapath stages.
package accel_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } mac_acc_state_t;

   localparam int unsigned ACC_WIDTH_DEF = 30;
   localparam int unsigned LEN_WIDTH_DEF = 10;

   // Two's-complement limits of a width-bit signed value, returned 64 bits wide.
   function automatic logic signed [63:0] SAT_MAX(input int unsigned width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] SAT_MIN(input int unsigned width);
      return -(64'sd1 <<< (width - 1));
   endfunction

endpackage

// File: rtl/mac_accumulator_beat_counter.sv
// Remaining-beat counter: loads a count, decrements on enable, flags the last beat.
module beat_counter #(
   parameter int unsigned WIDTH = 10
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             last
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign last = (count == WIDTH'(1));

endmodule

// File: rtl/mac_accumulator.sv
// Multiply-accumulate stage: sums len_in signed products, then holds the result for one transfer.
// Define MAC_ACCUMULATOR_SATURATE_EN to clamp each addition instead of wrapping.
module mac_accumulator
   import accel_pkg::*;
#(
   parameter int unsigned A_WIDTH   = 8,
   parameter int unsigned B_WIDTH   = 8,
   parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF,
   parameter int unsigned LEN_WIDTH = LEN_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 arst_n_in,
   input  logic [LEN_WIDTH-1:0] len_in,
   input  logic [A_WIDTH-1:0]   a_in,
   input  logic [B_WIDTH-1:0]   b_in,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [ACC_WIDTH-1:0] acc_out,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int unsigned PW = A_WIDTH + B_WIDTH;

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_ACCUM = ACCUM;
   localparam logic [1:0] ST_HOLD  = HOLD;

   logic [1:0]                  state;
   logic [1:0]                  state_nxt;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] acc_nxt;
   logic signed [ACC_WIDTH-1:0] base;
   logic signed [PW-1:0]        prod;
   logic signed [ACC_WIDTH-1:0] prod_ext;
   logic [LEN_WIDTH-1:0]        load_val;
   logic                        accept;
   logic                        last;

   assign in_ready  = (state != ST_HOLD);
   assign out_valid = (state == ST_HOLD);
   assign acc_out   = acc;

   assign accept   = in_valid && in_ready;
   assign load_val = (len_in == '0) ? '0 : len_in - LEN_WIDTH'(1);

   assign prod     = $signed(a_in) * $signed(b_in);
   assign prod_ext = ACC_WIDTH'(prod);
   // The first beat starts from zero so no clear cycle is needed between results.
   assign base     = (state == ST_IDLE) ? '0 : acc;

`ifdef MAC_ACCUMULATOR_SATURATE_EN
   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(SAT_MAX(ACC_WIDTH));
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(SAT_MIN(ACC_WIDTH));

   logic signed [ACC_WIDTH:0] sum_wide;

   assign sum_wide = {base[ACC_WIDTH-1], base} + {prod_ext[ACC_WIDTH-1], prod_ext};

   always_comb begin
      acc_nxt = sum_wide[ACC_WIDTH-1:0];
      if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
         acc_nxt = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      end
   end
`else
   assign acc_nxt = base + prod_ext;
`endif

   beat_counter #(
      .WIDTH (LEN_WIDTH)
   ) u_beat_counter (
      .clk      (clk),
      .arst_n   (arst_n_in),
      .load     (accept && (state == ST_IDLE)),
      .load_val (load_val),
      .dec      (accept && (state == ST_ACCUM)),
      .last     (last)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = (load_val == '0) ? ST_HOLD : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (accept && last) begin
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state <= ST_IDLE;
         acc   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            acc <= acc_nxt;
         end
      end
   end

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: vector table, scoreboard queue, corner sequences.
// Overflow expectations follow MAC_ACCUMULATOR_SATURATE_EN.
module tb_mac_accumulator;

   logic        clk = 1'b0;
   logic        arst_n_in;
   logic [9:0]  len_in;
   logic [7:0]  a_in;
   logic [7:0]  b_in;
   logic        in_valid;
   logic        in_ready;
   logic [29:0] acc_out;
   logic        out_valid;
   logic        out_ready;

   logic [9:0]  w_len;
   logic [7:0]  w_a;
   logic [7:0]  w_b;
   logic        w_valid;
   logic        w_in_ready;
   logic [15:0] w_acc;
   logic        w_out_valid;
   logic        w_out_ready;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [29:0] exp_q[$];

   typedef struct {
      logic [9:0]       len;
      int               nb;
      bit               gap;
      int               expv;
      logic [3:0][7:0]  a;
      logic [3:0][7:0]  b;
   } vec_t;

   vec_t vecs[6];

   always #5 clk = ~clk;

   mac_accumulator dut (
      .clk       (clk),
      .arst_n_in (arst_n_in),
      .len_in    (len_in),
      .a_in      (a_in),
      .b_in      (b_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .acc_out   (acc_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   mac_accumulator #(
      .ACC_WIDTH (16)
   ) dut16 (
      .clk       (clk),
      .arst_n_in (arst_n_in),
      .len_in    (w_len),
      .a_in      (w_a),
      .b_in      (w_b),
      .in_valid  (w_valid),
      .in_ready  (w_in_ready),
      .acc_out   (w_acc),
      .out_valid (w_out_valid),
      .out_ready (w_out_ready)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [9:0] len, input int nb, input bit gap, input int expv,
                               input int a0, input int b0, input int a1, input int b1,
                               input int a2, input int b2, input int a3, input int b3);
      vec_t v;
      v.len  = len;
      v.nb   = nb;
      v.gap  = gap;
      v.expv = expv;
      v.a[0] = 8'(a0); v.b[0] = 8'(b0);
      v.a[1] = 8'(a1); v.b[1] = 8'(b1);
      v.a[2] = 8'(a2); v.b[2] = 8'(b2);
      v.a[3] = 8'(a3); v.b[3] = 8'(b3);
      return v;
   endfunction

   // Called just after a rising edge; returns just after the edge that accepted the beat.
   task automatic drive_beat(input logic [7:0] a, input logic [7:0] b, input logic [9:0] len);
      int unsigned n = 0;
      a_in     = a;
      b_in     = b;
      len_in   = len;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Later beats carry len 1, which would end the sum early if it were re-sampled.
   task automatic run_vec(input vec_t v);
      for (int j = 0; j < v.nb; j++) begin
         if (j == v.nb - 1) exp_q.push_back(30'(v.expv));
         drive_beat(v.a[j], v.b[j], (j == 0) ? v.len : 10'd1);
         if (j < v.nb - 1) begin
            check("mid_out_valid", 64'(out_valid), 64'd0);
            check("mid_in_ready", 64'(in_ready), 64'd1);
            if (v.gap) begin
               @(posedge clk); #1;
            end
         end else begin
            check("latency_out_valid", 64'(out_valid), 64'd1);
         end
      end
      @(posedge clk); #1;
      check("back_to_idle", 64'(in_ready), 64'd1);
   endtask

   always @(negedge clk) begin
      if (arst_n_in && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got 0x%0h expected no transfer", acc_out);
         end else begin
            check("scoreboard_acc_out", 64'(acc_out), 64'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] e16;
      arst_n_in   = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      a_in        = '0;
      b_in        = '0;
      len_in      = '0;
      w_len       = '0;
      w_a         = '0;
      w_b         = '0;
      w_valid     = 1'b0;
      w_out_ready = 1'b1;

      vecs[0] = mk(10'd4, 4, 1'b0, 24,      1, 1,   2, -3,  -4, 5,  7, 7);
      vecs[1] = mk(10'd0, 1, 1'b0, 16384,   -128, -128,  0, 0,  0, 0,  0, 0);
      vecs[2] = mk(10'd3, 3, 1'b1, 300,     10, 10,  10, 10,  10, 10,  0, 0);
      vecs[3] = mk(10'd1, 1, 1'b0, 6,       2, 3,   0, 0,   0, 0,   0, 0);
      vecs[4] = mk(10'd2, 2, 1'b0, -32512,  -128, 127,  127, -128,  0, 0,  0, 0);
      vecs[5] = mk(10'd3, 3, 1'b0, -7,      -1, 1,  0, 5,  3, -2,  0, 0);

      repeat (2) @(posedge clk);
      #1;
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_acc_out", 64'(acc_out), 64'd0);
      check("reset_w_out_valid", 64'(w_out_valid), 64'd0);
      @(negedge clk);
      arst_n_in = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Abort a length-5 sum after three beats; the partial sum must vanish.
      drive_beat(8'd1, 8'd1, 10'd5);
      drive_beat(8'd1, 8'd1, 10'd5);
      drive_beat(8'd1, 8'd1, 10'd5);
      #2;
      arst_n_in = 1'b0;
      #1;
      check("rst_mid_out_valid", 64'(out_valid), 64'd0);
      check("rst_mid_in_ready", 64'(in_ready), 64'd1);
      check("rst_mid_acc_out", 64'(acc_out), 64'd0);
      @(negedge clk);
      arst_n_in = 1'b1;
      @(posedge clk); #1;
      run_vec(mk(10'd1, 1, 1'b0, 6, 2, 3, 0, 0, 0, 0, 0, 0));

      // Backpressure: result held, waiting beat not consumed until after the transfer.
      out_ready = 1'b0;
      drive_beat(8'd5, 8'd6, 10'd2);
      exp_q.push_back(30'd86);
      drive_beat(8'd7, 8'd8, 10'd2);
      a_in     = 8'd9;
      b_in     = 8'd9;
      len_in   = 10'd1;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_acc_stable", 64'(acc_out), 64'd86);
      end
      @(posedge clk); #1;
      exp_q.push_back(30'd81);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_in_ready", 64'(in_ready), 64'd1);
      check("bp_release_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_next_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
      check("bp_idle_again", 64'(in_ready), 64'd1);

      // 16-bit instance: positive and negative overflow over three beats.
      w_len   = 10'd3;
      w_a     = 8'd127;
      w_b     = 8'd127;
      w_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      w_valid = 1'b0;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
      e16 = 16'h7FFF;
`else
      e16 = 16'(-17149);
`endif
      check("ovf_pos_valid", 64'(w_out_valid), 64'd1);
      check("ovf_pos_value", 64'(w_acc), 64'(e16));
      @(posedge clk); #1;
      check("ovf_pos_done", 64'(w_out_valid), 64'd0);

      w_a     = 8'(-128);
      w_b     = 8'd127;
      w_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      w_valid = 1'b0;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
      e16 = 16'h8000;
`else
      e16 = 16'd16768;
`endif
      check("ovf_neg_valid", 64'(w_out_valid), 64'd1);
      check("ovf_neg_value", 64'(w_acc), 64'(e16));
      @(posedge clk); #1;

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
